// File: rtl/score_tile_tracker.sv
// Game score keeper: one-shot bonus/penalty tiles, per-second decay, saturating
// 0..MAX_SCORE, game over on reaching zero.
module score_tile_tracker #(
  parameter logic [7:0] START_SCORE = 8'd50,
  parameter logic [7:0] MAX_SCORE   = 8'd99,
  parameter logic [7:0] TILE_DELTA  = 8'd5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       playHard,
  input  logic       playMedium,
  input  logic       playEasy,
  input  logic       externalReset,
  input  logic [4:0] scorePlusFiveX,
  input  logic [4:0] scorePlusFiveY,
  input  logic [4:0] scoreMinusFiveX,
  input  logic [4:0] scoreMinusFiveY,
  input  logic [4:0] playerX,
  input  logic [4:0] playerY,
  input  logic       moveValid,
  input  logic       secTick,
  output logic [7:0] score,
  output logic       plusTaken,
  output logic       minusTaken,
  output logic       scoreEvent,
  output logic       gameOver
);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t            state, state_d;
  logic [7:0]        score_d;
  logic              plus_d, minus_d, event_d;
  logic              mode_valid, plus_hit, minus_hit;
  logic signed [8:0] delta;
  logic signed [9:0] sum;

  assign mode_valid = !externalReset &&
                      (( playHard && !playMedium && !playEasy) ||
                       (!playHard &&  playMedium && !playEasy) ||
                       (!playHard && !playMedium &&  playEasy));

  assign plus_hit  = moveValid && !plusTaken &&
                     (playerX == scorePlusFiveX) && (playerY == scorePlusFiveY);
  assign minus_hit = moveValid && !minusTaken &&
                     (playerX == scoreMinusFiveX) && (playerY == scoreMinusFiveY);

  always_comb begin
    delta = '0;
    if (plus_hit)  delta = delta + $signed({1'b0, TILE_DELTA});
    if (minus_hit) delta = delta - $signed({1'b0, TILE_DELTA});
    if (secTick)   delta = delta - 9'sd1;
    sum = $signed({2'b00, score}) + $signed({delta[8], delta});
  end

  always_comb begin
    state_d = state;
    score_d = score;
    plus_d  = plusTaken;
    minus_d = minusTaken;
    event_d = 1'b0;
    case (state)
      IDLE: begin
        score_d = START_SCORE;
        plus_d  = 1'b0;
        minus_d = 1'b0;
        if (mode_valid) state_d = PLAY;
      end
      PLAY: begin
        if (!mode_valid) begin
          state_d = IDLE;
          score_d = START_SCORE;
          plus_d  = 1'b0;
          minus_d = 1'b0;
        end else begin
          if (sum[9])
            score_d = '0;
          else if (sum > $signed({2'b00, MAX_SCORE}))
            score_d = MAX_SCORE;
          else
            score_d = sum[7:0];
          plus_d  = plusTaken  | plus_hit;
          minus_d = minusTaken | minus_hit;
          event_d = (score_d != score);
          if (score_d == '0) state_d = DONE;
        end
      end
      DONE: begin
        score_d = '0;
        if (!mode_valid) begin
          state_d = IDLE;
          score_d = START_SCORE;
          plus_d  = 1'b0;
          minus_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      score      <= START_SCORE;
      plusTaken  <= 1'b0;
      minusTaken <= 1'b0;
      scoreEvent <= 1'b0;
      gameOver   <= 1'b0;
    end else begin
      state      <= state_d;
      score      <= score_d;
      plusTaken  <= plus_d;
      minusTaken <= minus_d;
      scoreEvent <= event_d;
      gameOver   <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_score_tile_tracker.sv
// Directed bench for score_tile_tracker; extra instances start near the
// ceiling so saturation can be reached within one game.
module tb_score_tile_tracker;

  logic       clock = 1'b0;
  logic       reset;
  logic       playHard, playMedium, playEasy;
  logic       ext, ext_hi;
  logic [4:0] pX, pY, mX, mY, plX, plY;
  logic       moveValid, secTick;

  logic [7:0] score, score97, score99;
  logic       plusTaken, minusTaken, scoreEvent, gameOver;
  logic       plus97, minus97, ev97, go97;
  logic       plus99, minus99, ev99, go99;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  score_tile_tracker u_dut (
    .clock(clock), .reset(reset),
    .playHard(playHard), .playMedium(playMedium), .playEasy(playEasy),
    .externalReset(ext),
    .scorePlusFiveX(pX), .scorePlusFiveY(pY),
    .scoreMinusFiveX(mX), .scoreMinusFiveY(mY),
    .playerX(plX), .playerY(plY), .moveValid(moveValid), .secTick(secTick),
    .score(score), .plusTaken(plusTaken), .minusTaken(minusTaken),
    .scoreEvent(scoreEvent), .gameOver(gameOver)
  );

  score_tile_tracker #(.START_SCORE(8'd97)) u_97 (
    .clock(clock), .reset(reset),
    .playHard(playHard), .playMedium(playMedium), .playEasy(playEasy),
    .externalReset(ext_hi),
    .scorePlusFiveX(pX), .scorePlusFiveY(pY),
    .scoreMinusFiveX(mX), .scoreMinusFiveY(mY),
    .playerX(plX), .playerY(plY), .moveValid(moveValid), .secTick(secTick),
    .score(score97), .plusTaken(plus97), .minusTaken(minus97),
    .scoreEvent(ev97), .gameOver(go97)
  );

  score_tile_tracker #(.START_SCORE(8'd99)) u_99 (
    .clock(clock), .reset(reset),
    .playHard(playHard), .playMedium(playMedium), .playEasy(playEasy),
    .externalReset(ext_hi),
    .scorePlusFiveX(pX), .scorePlusFiveY(pY),
    .scoreMinusFiveX(mX), .scoreMinusFiveY(mY),
    .playerX(plX), .playerY(plY), .moveValid(moveValid), .secTick(secTick),
    .score(score99), .plusTaken(plus99), .minusTaken(minus99),
    .scoreEvent(ev99), .gameOver(go99)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic move(input logic [4:0] x, input logic [4:0] y, input logic tick);
    plX = x; plY = y; moveValid = 1'b1; secTick = tick;
    step();
    moveValid = 1'b0; secTick = 1'b0;
  endtask

  task automatic set_mode(input logic h, input logic m, input logic e);
    playHard = h; playMedium = m; playEasy = e;
  endtask

  initial begin
    reset = 1'b1; ext = 1'b1; ext_hi = 1'b1;
    set_mode(0, 0, 0);
    pX = 5'd17; pY = 5'd9; mX = 5'd10; mY = 5'd6;
    plX = '0; plY = '0; moveValid = 1'b0; secTick = 1'b0;
    step(2);
    reset = 1'b0;
    check("rst_score", score, 50);
    check("rst_flags", {plusTaken, minusTaken, scoreEvent, gameOver}, 0);

    // easy game: bonus once only
    set_mode(0, 0, 1); ext = 1'b0;
    step();
    move(5'd17, 5'd9, 1'b0);
    check("bonus_score", score, 55);
    check("bonus_flag", plusTaken, 1);
    check("bonus_event", scoreEvent, 1);
    step();
    check("bonus_event_end", scoreEvent, 0);
    move(5'd17, 5'd9, 1'b0);
    check("bonus_again", score, 55);
    check("bonus_again_ev", scoreEvent, 0);
    plX = 5'd10; plY = 5'd6;
    step();
    check("no_move_penalty", {minusTaken, score}, 55);

    // externalReset back to idle
    ext = 1'b1;
    step();
    check("ext_idle_score", score, 50);
    check("ext_idle_flag", plusTaken, 0);

    // medium: events in the IDLE cycle are ignored
    set_mode(0, 1, 0); ext = 1'b0;
    move(5'd10, 5'd6, 1'b1);
    check("idle_ignored", {minusTaken, score}, 50);
    move(5'd10, 5'd6, 1'b1);
    check("pen_tick_score", score, 44);
    check("pen_tick_flag", minusTaken, 1);
    check("pen_tick_event", scoreEvent, 1);
    set_mode(0, 1, 1);
    step();
    check("multi_mode_idle", score, 50);

    // bonus and penalty on the same tile
    set_mode(0, 1, 0);
    pX = 5'd5; pY = 5'd5; mX = 5'd5; mY = 5'd5;
    step();
    move(5'd5, 5'd5, 1'b0);
    check("same_tile_score", score, 50);
    check("same_tile_flags", {plusTaken, minusTaken}, 3);
    check("same_tile_event", scoreEvent, 0);

    // decay down to 3 then penalty to zero
    ext = 1'b1; step();
    ext = 1'b0;
    pX = 5'd17; pY = 5'd9; mX = 5'd10; mY = 5'd6;
    step();
    secTick = 1'b1;
    step(47);
    secTick = 1'b0;
    check("decay_to_3", score, 3);
    move(5'd10, 5'd6, 1'b0);
    check("zero_score", score, 0);
    check("zero_gameover", gameOver, 1);
    check("zero_event", scoreEvent, 1);
    move(5'd17, 5'd9, 1'b1);
    check("done_hold", score, 0);
    check("done_ignore", {plusTaken, scoreEvent, gameOver}, 1);
    ext = 1'b1;
    step();
    check("done_exit_score", score, 50);
    check("done_exit_go", gameOver, 0);

    // reset mid-game
    set_mode(1, 0, 0); ext = 1'b0;
    step();
    move(5'd17, 5'd9, 1'b0);
    secTick = 1'b1;
    step(32);
    secTick = 1'b0;
    check("mid_score", score, 23);
    check("mid_flag", plusTaken, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_score", score, 50);
    check("mid_rst_flags", {plusTaken, minusTaken}, 0);
    set_mode(0, 0, 0);
    move(5'd17, 5'd9, 1'b1);
    move(5'd17, 5'd9, 1'b1);
    check("zero_mode_idle", {plusTaken, score}, 50);

    // saturation at the ceiling
    ext = 1'b1; ext_hi = 1'b0;
    set_mode(0, 0, 1);
    step();
    move(5'd17, 5'd9, 1'b0);
    check("sat97_score", score97, 99);
    check("sat97_event", ev97, 1);
    check("sat99_score", score99, 99);
    check("sat99_event", ev99, 0);
    check("sat99_flag", plus99, 1);
    check("main_held_idle", score, 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
